ram_burst_reader: RTL and testbench

RAM_BURST_READER -- requirements
Module: ram_burst_reader

---
 rtl/ram_burst_reader.sv | 127 ++++++++++++
 tb/tb_ram_burst_reader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_reader.sv
// Burst reader: streams len words from a synchronous RAM, starting at base_addr,
// through a 2-entry output FIFO with a ready/valid handshake.
module ram_burst_reader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W:0]   i_len,
  output logic              o_re,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_last_addr;
  logic [ADDR_W:0]     r_remaining;
  logic                r_inflight;
  logic [DATA_W-1:0]   r_fifo [2];
  logic                r_head;
  logic                r_tail;
  logic [1:0]          r_occ;
  logic                w_re;
  logic                w_xfer;
  logic [2:0]          w_load;

  assign w_xfer = o_out_valid & i_out_ready;

  // A word leaving this cycle frees its slot in time for a read issued now,
  // which is what sustains one word per cycle with the sink always ready.
  assign w_load = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_xfer};

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_re        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = (i_len != '0) ? S_READ : S_DONE;
        end
      end
      S_READ: begin
        w_re = (r_remaining != '0) && (w_load < 3'd2);
        if (w_re && (r_remaining == (ADDR_W+1)'(1))) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!r_inflight && (r_occ == 2'd0)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: the two FIFO entries are reset because out_data must read zero out of
  // reset; a larger buffer would be left unreset and gated by valid instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_last_addr <= '0;
      r_remaining <= '0;
      r_inflight  <= 1'b0;
      r_fifo[0]   <= '0;
      r_fifo[1]   <= '0;
      r_head      <= 1'b0;
      r_tail      <= 1'b0;
      r_occ       <= 2'd0;
    end else begin
      if ((r_state == S_IDLE) && i_start) begin
        r_addr      <= i_base_addr;
        r_remaining <= i_len;
      end else if (w_re) begin
        r_addr      <= r_addr + 1'b1;
        r_remaining <= r_remaining - 1'b1;
        r_last_addr <= r_addr;
      end
      r_inflight <= w_re;
      if (r_inflight) begin
        r_fifo[r_tail] <= i_rd_data;
        r_tail         <= ~r_tail;
      end
      if (w_xfer) begin
        r_head <= ~r_head;
      end
      r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_xfer};
    end
  end

  assign o_re        = w_re;
  assign o_rd_addr   = w_re ? r_addr : r_last_addr;
  assign o_out_valid = (r_occ != 2'd0);
  assign o_out_data  = r_fifo[r_head];
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);

endmodule

// File: tb/tb_ram_burst_reader.sv
// Self-checking bench for ram_burst_reader: table-driven bursts, a reset
// sequence and random bursts checked against a queue-based stream model.
module tb_ram_burst_reader;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  logic              clk;
  logic              rst;
  logic              i_start;
  logic [ADDR_W-1:0] i_base_addr;
  logic [ADDR_W:0]   i_len;
  logic              o_re;
  logic [ADDR_W-1:0] o_rd_addr;
  logic [DATA_W-1:0] i_rd_data;
  logic [DATA_W-1:0] o_out_data;
  logic              o_out_valid;
  logic              i_out_ready;
  logic              o_busy;
  logic              o_done;

  logic [DATA_W-1:0] mem [DEPTH];
  int checks   = 0;
  int failures = 0;

  // Stream model: the words the burst must deliver, in order, plus the
  // expected address sequence and the buffer fill it implies.
  logic [DATA_W-1:0] exp_q [$];
  int exp_addr;
  int issued;
  int rcvd;
  int m_occ;
  int m_if;
  bit en_mon;

  typedef struct {
    int base;
    int len;
    int mode;             // 0: ready always, 1: ready 1,0,0,1,0,1..., 2: random
    int inj_c;            // cycle to pulse a stray start, -1 for none
    int inj_base;
    int inj_len;
    int exp_first_valid;  // cycle of first out_valid after accept, -1 for never
    int exp_done_c;       // cycle of done after accept, -1 for don't care
  } vec_t;

  vec_t vecs [7];

  ram_burst_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_base_addr (i_base_addr),
    .i_len       (i_len),
    .o_re        (o_re),
    .o_rd_addr   (o_rd_addr),
    .i_rd_data   (i_rd_data),
    .o_out_data  (o_out_data),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous RAM: data appears one clock after the read enable.
  always @(posedge clk) begin
    if (o_re) i_rd_data <= mem[o_rd_addr];
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic rdy(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return ((c % 6) == 0) || ((c % 6) == 3) || ((c % 6) == 5);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  always @(negedge clk) begin
    logic xfer;
    if (rst) begin
      m_occ = 0;
      m_if  = 0;
    end else if (en_mon) begin
      xfer = o_out_valid && i_out_ready;
      check("out_valid", int'(o_out_valid), int'(m_occ != 0));
      if (o_re) begin
        check("credit", int'((m_occ + m_if - int'(xfer)) < 2), 1);
        check("rd_addr", int'(o_rd_addr), exp_addr);
        exp_addr = (exp_addr + 1) % DEPTH;
        issued++;
      end
      if (xfer) begin
        rcvd++;
        if (exp_q.size() != 0) check("out_data", int'(o_out_data), int'(exp_q.pop_front()));
      end
      m_occ = m_occ + m_if - int'(xfer);
      m_if  = int'(o_re);
    end
  end

  // Call between edges; start is accepted on the next rising edge.
  task automatic run_burst(input vec_t v);
    int c;
    bit seen;
    int first_valid, first_re, last_re, first_x, last_x, done_c;
    exp_q.delete();
    for (int k = 0; k < v.len; k++) exp_q.push_back(mem[(v.base + k) % DEPTH]);
    exp_addr = v.base;
    issued = 0;
    rcvd   = 0;
    m_occ  = 0;
    m_if   = 0;
    en_mon = 1'b1;
    i_start     = 1'b1;
    i_base_addr = ADDR_W'(v.base);
    i_len       = (ADDR_W+1)'(v.len);
    i_out_ready = 1'b1;
    @(posedge clk); #1;
    first_valid = -1; first_re = -1; last_re = -1;
    first_x = -1; last_x = -1; done_c = -1;
    seen = 1'b0;
    c = 0;
    while (!seen && c < 300) begin
      i_out_ready = rdy(v.mode, c);
      if (c == v.inj_c) begin
        i_start     = 1'b1;
        i_base_addr = ADDR_W'(v.inj_base);
        i_len       = (ADDR_W+1)'(v.inj_len);
      end else begin
        i_start = 1'b0;
      end
      @(negedge clk);
      if (o_re) begin
        if (first_re < 0) first_re = c;
        last_re = c;
      end
      if (o_out_valid && first_valid < 0) first_valid = c;
      if (o_out_valid && i_out_ready) begin
        if (first_x < 0) first_x = c;
        last_x = c;
      end
      if (o_done) begin
        seen   = 1'b1;
        done_c = c;
      end
      @(posedge clk); #1;
      c++;
    end
    i_start     = 1'b0;
    i_out_ready = 1'b1;
    check("done_seen", int'(seen), 1);
    check("first_valid", first_valid, v.exp_first_valid);
    if (v.exp_done_c >= 0) check("done_cycle", done_c, v.exp_done_c);
    if (v.mode == 0 && v.len > 0) begin
      check("re_span", last_re - first_re, v.len - 1);
      check("xfer_span", last_x - first_x, v.len - 1);
    end
    @(negedge clk);
    check("done_once", int'(o_done), 0);
    check("busy_after", int'(o_busy), 0);
    check("words", rcvd, v.len);
    check("issued", issued, v.len);
    check("leftover", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t rv;
    vecs[0] = '{0, 8,  0, -1, 0, 0,  2, -1};
    vecs[1] = '{6, 4,  0, -1, 0, 0,  2, -1};
    vecs[2] = '{0, 8,  1, -1, 0, 0,  2, -1};
    vecs[3] = '{0, 0,  0, -1, 0, 0, -1,  0};
    vecs[4] = '{3, 5,  0,  2, 1, 7,  2, -1};
    vecs[5] = '{5, 15, 2, -1, 0, 0,  2, -1};
    vecs[6] = '{7, 1,  0, -1, 0, 0,  2, -1};

    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(i);
    en_mon      = 1'b0;
    rst         = 1'b1;
    i_start     = 1'b0;
    i_base_addr = '0;
    i_len       = '0;
    i_out_ready = 1'b1;
    i_rd_data   = '0;

    #12;
    check("rst_re", int'(o_re), 0);
    check("rst_rd_addr", int'(o_rd_addr), 0);
    check("rst_out_valid", int'(o_out_valid), 0);
    check("rst_out_data", int'(o_out_data), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_done", int'(o_done), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) run_burst(vecs[i]);

    // Reset in the 4th cycle of a len=8 burst.
    en_mon      = 1'b0;
    i_start     = 1'b1;
    i_base_addr = '0;
    i_len       = 4'd8;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_busy", int'(o_busy), 1);
    check("pre_rst_re", int'(o_re), 1);
    check("pre_rst_valid", int'(o_out_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_re", int'(o_re), 0);
    check("mid_rst_valid", int'(o_out_valid), 0);
    check("mid_rst_busy", int'(o_busy), 0);
    check("mid_rst_done", int'(o_done), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_done", int'(o_done), 0);
      check("post_rst_busy", int'(o_busy), 0);
      check("post_rst_valid", int'(o_out_valid), 0);
    end
    @(posedge clk); #1;
    rv = '{2, 2, 0, -1, 0, 0, 2, -1};
    run_burst(rv);

    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
      rv.base            = int'($urandom_range(0, DEPTH - 1));
      rv.len             = int'($urandom_range(0, 15));
      rv.mode            = 2;
      rv.inj_c           = int'($urandom_range(0, 6)) - 1;
      rv.inj_base        = int'($urandom_range(0, DEPTH - 1));
      rv.inj_len         = int'($urandom_range(0, 15));
      rv.exp_first_valid = (rv.len == 0) ? -1 : 2;
      rv.exp_done_c      = (rv.len == 0) ? 0 : -1;
      run_burst(rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
